// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage_if
// Brief    : ID/EX operand-stage bus: decoded instruction in, forwarding
//            sources in, ALU operands and EX control out.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
);
  logic                     id_valid;
  logic [REG_ADDR_W-1:0]    id_rs1;
  logic [REG_ADDR_W-1:0]    id_rs2;
  logic                     id_use_rs1;
  logic                     id_use_rs2;
  logic [DATA_WIDTH-1:0]    id_rs1_data;
  logic [DATA_WIDTH-1:0]    id_rs2_data;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic                     id_alu_src;
  logic [OPCODE_LENGTH-1:0] id_operation;
  logic [REG_ADDR_W-1:0]    id_rd;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     hold;
  logic                     flush;
  logic [REG_ADDR_W-1:0]    mem_rd;
  logic                     mem_reg_write;
  logic [DATA_WIDTH-1:0]    mem_result;
  logic [REG_ADDR_W-1:0]    wb_rd;
  logic                     wb_reg_write;
  logic [DATA_WIDTH-1:0]    wb_result;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic                     ex_valid;
  logic [REG_ADDR_W-1:0]    ex_rd;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     id_stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rs1_data,
           id_rs2_data, id_imm, id_alu_src, id_operation, id_rd,
           id_reg_write, id_mem_read, hold, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    input  SrcA, SrcB, Operation, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, id_stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rs1_data,
           id_rs2_data, id_imm, id_alu_src, id_operation, id_rd,
           id_reg_write, id_mem_read, hold, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    output SrcA, SrcB, Operation, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, id_stall
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Brief    : ID/EX pipeline register with EX/MEM and MEM/WB forwarding,
//            load-use bubble insertion and ALU operand selection.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  id_ex_operand_stage_if.slave bus
);

  logic                     r_valid;
  logic [REG_ADDR_W-1:0]    r_rs1;
  logic [REG_ADDR_W-1:0]    r_rs2;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic                     r_alu_src;
  logic [OPCODE_LENGTH-1:0] r_operation;
  logic [REG_ADDR_W-1:0]    r_rd;
  logic                     r_reg_write;
  logic                     r_mem_read;

  logic                     w_rs1_hit;
  logic                     w_rs2_hit;
  logic                     w_load_use;
  logic [DATA_WIDTH-1:0]    w_fwd_rs1;
  logic [DATA_WIDTH-1:0]    w_fwd_rs2;

  // Load in EX whose result the instruction in ID needs one cycle too early
  assign w_rs1_hit  = bus.id_use_rs1 && (bus.id_rs1 == r_rd);
  assign w_rs2_hit  = bus.id_use_rs2 && (bus.id_rs2 == r_rd);
  assign w_load_use = bus.id_valid && r_valid && r_mem_read &&
                      (r_rd != '0) && (w_rs1_hit || w_rs2_hit);

  assign bus.id_stall = !bus.flush && (bus.hold || w_load_use);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_operation <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (bus.flush || (!bus.hold && w_load_use)) begin
      // Bubble: operand data is left as-is, only control is killed
      r_valid     <= 1'b0;
      r_operation <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (!bus.hold) begin
      r_valid     <= bus.id_valid;
      r_rs1       <= bus.id_rs1;
      r_rs2       <= bus.id_rs2;
      r_rs1_data  <= bus.id_rs1_data;
      r_rs2_data  <= bus.id_rs2_data;
      r_imm       <= bus.id_imm;
      r_alu_src   <= bus.id_alu_src;
      r_operation <= bus.id_operation;
      r_rd        <= bus.id_rd;
      r_reg_write <= bus.id_reg_write && bus.id_valid;
      r_mem_read  <= bus.id_mem_read && bus.id_valid;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_rs1)) begin
      w_fwd_rs1 = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rs1)) begin
      w_fwd_rs1 = bus.wb_result;
    end
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_rs2)) begin
      w_fwd_rs2 = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rs2)) begin
      w_fwd_rs2 = bus.wb_result;
    end
  end

  assign bus.SrcA          = w_fwd_rs1;
  assign bus.SrcB          = r_alu_src ? r_imm : w_fwd_rs2;
  assign bus.ex_store_data = w_fwd_rs2;
  assign bus.Operation     = r_operation;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_reg_write  = r_reg_write;
  assign bus.ex_mem_read   = r_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Brief    : Directed vector table plus randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } instr_t;

  typedef struct packed {
    logic        chk;
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [3:0]  op;
    logic        stall;
    logic        chkd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        hold;
    logic        flush;
    instr_t      id;
    logic        mem_rw;
    logic [4:0]  mem_rd;
    logic [31:0] mem_res;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    exp_t        e;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_ex_operand_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) bus ();

  id_ex_operand_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX
  instr_t cur;
  instr_t m;
  logic   m_known;

  function automatic instr_t f_idle();
    instr_t r = '0;
    return r;
  endfunction

  function automatic instr_t f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op);
    instr_t r = '0;
    r.valid = 1'b1; r.rs1 = rs1; r.rs2 = rs2; r.use1 = 1'b1; r.use2 = 1'b1;
    r.d1 = d1; r.d2 = d2; r.op = op; r.rd = rd; r.rw = 1'b1;
    return r;
  endfunction

  function automatic instr_t f_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [31:0] d1, input logic [31:0] imm);
    instr_t r = '0;
    r.valid = 1'b1; r.rs1 = rs1; r.use1 = 1'b1; r.d1 = d1; r.imm = imm;
    r.alu_src = 1'b1; r.op = 4'b0010; r.rd = rd; r.rw = 1'b1; r.mr = 1'b1;
    return r;
  endfunction

  function automatic exp_t e_ctl(input logic valid, input logic [4:0] rd, input logic rw,
                                 input logic mr, input logic [3:0] op, input logic stall);
    exp_t e = '0;
    e.chk = 1'b1; e.valid = valid; e.rd = rd; e.rw = rw; e.mr = mr; e.op = op; e.stall = stall;
    return e;
  endfunction

  function automatic exp_t e_dat(input exp_t e_in, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] sd);
    exp_t e = e_in;
    e.chkd = 1'b1; e.a = a; e.b = b; e.sd = sd;
    return e;
  endfunction

  function automatic vec_t v(input logic rst, input logic hold, input logic flush, input instr_t id,
                             input logic mem_rw, input logic [4:0] mem_rd, input logic [31:0] mem_res,
                             input logic wb_rw, input logic [4:0] wb_rd, input logic [31:0] wb_res,
                             input exp_t e);
    vec_t r;
    r.rst = rst; r.hold = hold; r.flush = flush; r.id = id;
    r.mem_rw = mem_rw; r.mem_rd = mem_rd; r.mem_res = mem_res;
    r.wb_rw = wb_rw; r.wb_rd = wb_rd; r.wb_res = wb_res; r.e = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic hold, input logic flush, input instr_t id,
                       input logic mem_rw, input logic [4:0] mem_rd, input logic [31:0] mem_res,
                       input logic wb_rw, input logic [4:0] wb_rd, input logic [31:0] wb_res);
    reset = rst;
    cur   = id;
    bus.hold = hold;           bus.flush = flush;
    bus.id_valid = id.valid;   bus.id_rs1 = id.rs1;        bus.id_rs2 = id.rs2;
    bus.id_use_rs1 = id.use1;  bus.id_use_rs2 = id.use2;
    bus.id_rs1_data = id.d1;   bus.id_rs2_data = id.d2;    bus.id_imm = id.imm;
    bus.id_alu_src = id.alu_src; bus.id_operation = id.op; bus.id_rd = id.rd;
    bus.id_reg_write = id.rw;  bus.id_mem_read = id.mr;
    bus.mem_reg_write = mem_rw; bus.mem_rd = mem_rd;       bus.mem_result = mem_res;
    bus.wb_reg_write = wb_rw;  bus.wb_rd = wb_rd;          bus.wb_result = wb_res;
  endtask

  // Value the ALU should see for a source register given the pipeline's producers
  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] regfile_val);
    if (rs == 5'd0) return regfile_val;
    if (bus.mem_reg_write && bus.mem_rd == rs) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_result;
    return regfile_val;
  endfunction

  function automatic logic ref_load_use();
    logic needs1 = cur.use1 && cur.rs1 == m.rd;
    logic needs2 = cur.use2 && cur.rs2 == m.rd;
    return cur.valid && m.valid && m.mr && m.rd != 5'd0 && (needs1 || needs2);
  endfunction

  function automatic exp_t ref_expect();
    exp_t e = e_ctl(m.valid, m.rd, m.rw, m.mr, m.op, !bus.flush && (bus.hold || ref_load_use()));
    if (m_known)
      e = e_dat(e, ref_operand(m.rs1, m.d1),
                m.alu_src ? m.imm : ref_operand(m.rs2, m.d2),
                ref_operand(m.rs2, m.d2));
    return e;
  endfunction

  task automatic ref_edge();
    logic lu = ref_load_use();
    if (reset) begin
      m = '0; m_known = 1'b1;
    end else if (bus.flush || (!bus.hold && lu)) begin
      m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.rd = '0; m.op = '0; m_known = 1'b0;
    end else if (!bus.hold) begin
      m = cur;
      m.rw = cur.rw && cur.valid;
      m.mr = cur.mr && cur.valid;
      m_known = 1'b1;
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    if (e.chk) begin
      chk({tag, " ex_valid"},     32'(bus.ex_valid),     32'(e.valid));
      chk({tag, " ex_rd"},        32'(bus.ex_rd),        32'(e.rd));
      chk({tag, " ex_reg_write"}, 32'(bus.ex_reg_write), 32'(e.rw));
      chk({tag, " ex_mem_read"},  32'(bus.ex_mem_read),  32'(e.mr));
      chk({tag, " Operation"},    32'(bus.Operation),    32'(e.op));
      chk({tag, " id_stall"},     32'(bus.id_stall),     32'(e.stall));
    end
    if (e.chk && e.chkd) begin
      chk({tag, " SrcA"},          bus.SrcA,          e.a);
      chk({tag, " SrcB"},          bus.SrcB,          e.b);
      chk({tag, " ex_store_data"}, bus.ex_store_data, e.sd);
    end
  endtask

  vec_t   tbl [18];
  instr_t add3, lw4, add5, add7, idle;
  exp_t   ez, eadd3;

  initial begin
    checks = 0; errors = 0; m = '0; m_known = 1'b0;
    idle  = f_idle();
    add3  = f_add(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 4'b0010);
    lw4   = f_lw(5'd4, 5'd1, 32'd100, 32'd16);
    add5  = f_add(5'd5, 5'd4, 5'd6, 32'h111, 32'd9, 4'b0010);
    add7  = f_add(5'd7, 5'd1, 5'd2, 32'd5, 32'd7, 4'b0010);
    ez    = e_dat(e_ctl(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0), 32'd0, 32'd0, 32'd0);
    eadd3 = e_dat(e_ctl(1'b1, 5'd3, 1'b1, 1'b0, 4'b0010, 1'b1), 32'd5, 32'd7, 32'd7);

    tbl[0]  = v(1, 0, 0, idle, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  '0);
    tbl[1]  = v(1, 0, 0, idle, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  ez);
    tbl[2]  = v(0, 0, 0, add3, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  ez);
    tbl[3]  = v(0, 1, 0, lw4,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  eadd3);
    tbl[4]  = v(0, 1, 0, lw4,  1, 5'd1, 32'hAA, 1, 5'd1, 32'hBB, e_dat(eadd3, 32'hAA, 32'd7, 32'd7));
    tbl[5]  = v(0, 1, 0, lw4,  0, 5'd1, 32'hAA, 1, 5'd1, 32'hBB, e_dat(eadd3, 32'hBB, 32'd7, 32'd7));
    tbl[6]  = v(0, 1, 0, lw4,  1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB, eadd3);
    tbl[7]  = v(0, 0, 0, lw4,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,
                e_dat(e_ctl(1, 5'd3, 1, 0, 4'b0010, 0), 32'd5, 32'd7, 32'd7));
    tbl[8]  = v(0, 0, 0, add5, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,
                e_dat(e_ctl(1, 5'd4, 1, 1, 4'b0010, 1), 32'd100, 32'd16, 32'd0));
    tbl[9]  = v(0, 0, 0, add5, 1, 5'd4, 32'h44, 0, 5'd0, 32'h0,
                e_ctl(0, 5'd0, 0, 0, 4'd0, 0));
    tbl[10] = v(0, 0, 0, lw4,  1, 5'd4, 32'h44, 0, 5'd0, 32'h0,
                e_dat(e_ctl(1, 5'd5, 1, 0, 4'b0010, 0), 32'h44, 32'd9, 32'd9));
    tbl[11] = v(0, 0, 1, add5, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,
                e_dat(e_ctl(1, 5'd4, 1, 1, 4'b0010, 0), 32'd100, 32'd16, 32'd0));
    tbl[12] = v(0, 0, 0, add7, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,
                e_ctl(0, 5'd0, 0, 0, 4'd0, 0));
    tbl[13] = v(0, 1, 1, idle, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,
                e_dat(e_ctl(1, 5'd7, 1, 0, 4'b0010, 0), 32'd5, 32'd7, 32'd7));
    tbl[14] = v(0, 0, 0, add3, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,
                e_ctl(0, 5'd0, 0, 0, 4'd0, 0));
    tbl[15] = v(1, 0, 0, idle, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,
                e_dat(e_ctl(1, 5'd3, 1, 0, 4'b0010, 0), 32'd5, 32'd7, 32'd7));
    tbl[16] = v(1, 0, 0, idle, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  ez);
    tbl[17] = v(0, 0, 0, idle, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  ez);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].hold, tbl[i].flush, tbl[i].id,
            tbl[i].mem_rw, tbl[i].mem_rd, tbl[i].mem_res,
            tbl[i].wb_rw, tbl[i].wb_rd, tbl[i].wb_res);
      @(negedge clk);
      compare($sformatf("vec%0d", i), tbl[i].e);
      @(posedge clk);
      ref_edge();
      #1;
    end

    for (int n = 0; n < 2000; n++) begin
      instr_t r;
      r.valid   = ($urandom_range(0, 3) != 0);
      r.rs1     = 5'($urandom_range(0, 3));
      r.rs2     = 5'($urandom_range(0, 3));
      r.use1    = 1'($urandom);
      r.use2    = 1'($urandom);
      r.d1      = $urandom;
      r.d2      = $urandom;
      r.imm     = $urandom;
      r.alu_src = 1'($urandom);
      r.op      = 4'($urandom_range(0, 15));
      r.rd      = 5'($urandom_range(0, 3));
      r.rw      = 1'($urandom);
      r.mr      = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, r,
            1'($urandom), 5'($urandom_range(0, 3)), $urandom,
            1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      @(negedge clk);
      compare($sformatf("rand%0d", n), ref_expect());
      @(posedge clk);
      ref_edge();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
